// File: rtl/fme_sad_pkg.sv
// Shared defaults and FSM encoding for the FME best-SAD sequencer.
package fme_sad_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int SAD_W_DEF     = DATAWIDTH_DEF + 9;
  localparam int NUM_CAND_DEF  = 9;
  localparam int IDX_W_DEF     = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } sad_state_t;

endpackage

// File: rtl/sad_compare.sv
// Combinational unsigned SAD comparator: lt is set when new_sad is strictly below cur_sad.
module sad_compare #(
  parameter int SAD_W = 17
) (
  input  logic [SAD_W-1:0] cur_sad,
  input  logic [SAD_W-1:0] new_sad,
  output logic             lt
);

  // Zero-extended subtraction: the extra top bit is the borrow, so full-scale values never overflow.
  logic signed [SAD_W:0] diff;

  assign diff = $signed({1'b0, new_sad}) - $signed({1'b0, cur_sad});
  assign lt   = diff[SAD_W];

endmodule

// File: rtl/best_sad_sequencer.sv
// Runs one SAD minimum search per start command; optional early exit under SAD_EARLY_EXIT_EN.
module best_sad_sequencer
  import fme_sad_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int NUM_CAND  = NUM_CAND_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATAWIDTH+8:0]   sad_in,
  input  logic                   sad_valid,
  output logic                   sad_ready,
  output logic [DATAWIDTH+8:0]   best_sad,
  output logic [IDX_W-1:0]       best_idx,
  output logic                   busy,
`ifdef SAD_EARLY_EXIT_EN
  input  logic [DATAWIDTH+8:0]   early_thr,
  output logic                   early_exit,
`endif
  output logic                   done
);

  localparam int SAD_W = DATAWIDTH + 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  sad_state_t       state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             accept;
  logic             new_lt;
  logic             early_hit;

  sad_compare #(.SAD_W(SAD_W)) u_best_cmp (
    .cur_sad (best_sad),
    .new_sad (sad_in),
    .lt      (new_lt)
  );

`ifdef SAD_EARLY_EXIT_EN
  logic thr_lt;

  // thr_lt means early_thr < sad_in, so its inverse is sad_in <= early_thr.
  sad_compare #(.SAD_W(SAD_W)) u_thr_cmp (
    .cur_sad (sad_in),
    .new_sad (early_thr),
    .lt      (thr_lt)
  );

  assign early_hit = ~thr_lt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      early_exit <= 1'b0;
    end else if (state == IDLE && start) begin
      early_exit <= 1'b0;
    end else if (accept && early_hit) begin
      early_exit <= 1'b1;
    end
  end
`else
  assign early_hit = 1'b0;
`endif

  assign accept = sad_valid && (state == COLLECT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sad_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = COLLECT;
      end
      COLLECT: begin
        sad_ready = 1'b1;
        busy      = 1'b1;
        if (accept && (cnt == LAST_IDX || early_hit)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // First beat loads unconditionally; later beats replace only when strictly smaller, so ties keep the earliest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      best_sad <= '0;
      best_idx <= '0;
    end else if (state == IDLE && start) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + IDX_W'(1);
      if (cnt == '0 || new_lt) begin
        best_sad <= sad_in;
        best_idx <= cnt;
      end
    end
  end

endmodule
